// File: rtl/alu_arbiter_if.sv
// Bundles the request, ALU-side and response signals of the two-requester ALU arbiter.
// slave is the arbiter's view; master is the combined client/ALU/consumer view.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b1;
    logic [4:0]        req_shamt0;
    logic [4:0]        req_shamt1;
    logic [3:0]        req_ctrl0;
    logic [3:0]        req_ctrl1;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [4:0]        alu_shamt;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1,
        input  req_shamt0, req_shamt1, req_ctrl0, req_ctrl1,
        output req_ready,
        output alu_a, alu_b, alu_shamt, alu_control,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1,
        output req_shamt0, req_shamt1, req_ctrl0, req_ctrl1,
        input  req_ready,
        input  alu_a, alu_b, alu_shamt, alu_control,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer for one shared ALU: request -> response in 2 cycles, one op per 3 cycles,
// RESP holds while rsp_ready is low and req_ready stays 0 outside IDLE. ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;

    logic              grant_id;
    logic [1:0]        req_ready_w;
    logic              handshake;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_id = ~bus.req_valid[0];
    end
`else
    logic last_q, last_d;

    // On a tie the requester not granted last time wins; otherwise the lone valid one.
    always_comb begin
        if (&bus.req_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = ~bus.req_valid[0];
        end
    end

    always_comb begin
        last_d = last_q;
        if (handshake) begin
            last_d = grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        req_ready_w = 2'b00;
        if (rst_n && (state_q == IDLE) && (|bus.req_valid)) begin
            req_ready_w = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign handshake = |(bus.req_valid & req_ready_w);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        shamt_d  = shamt_q;
        ctrl_d   = ctrl_q;
        id_d     = id_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = EXEC;
                    id_d    = grant_id;
                    a_d     = grant_id ? bus.req_a1     : bus.req_a0;
                    b_d     = grant_id ? bus.req_b1     : bus.req_b0;
                    shamt_d = grant_id ? bus.req_shamt1 : bus.req_shamt0;
                    ctrl_d  = grant_id ? bus.req_ctrl1  : bus.req_ctrl0;
                end
            end
            EXEC: begin
                state_d  = RESP;
                result_d = bus.alu_result;
                zero_d   = bus.alu_zero;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            ctrl_q   <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shamt_q  <= shamt_d;
            ctrl_q   <= ctrl_d;
            id_q     <= id_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // ALU inputs are forced to 0 outside EXEC (control 0 = AND) so the ALU stays quiet.
    logic exec_w;
    assign exec_w = rst_n && (state_q == EXEC);

    assign bus.req_ready   = req_ready_w;
    assign bus.alu_a       = exec_w ? a_q     : '0;
    assign bus.alu_b       = exec_w ? b_q     : '0;
    assign bus.alu_shamt   = exec_w ? shamt_q : 5'd0;
    assign bus.alu_control = exec_w ? ctrl_q  : 4'd0;
    assign bus.rsp_valid   = rst_n && (state_q == RESP);
    assign bus.rsp_id      = id_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_zero    = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU closing the loop.
module tb_alu_arbiter;
    localparam int DATA_W = 32;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_arbiter_if #(.DATA_W(DATA_W)) bus ();

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] alu_res;
    always_comb begin
        case (bus.alu_control)
            4'b0000: alu_res = bus.alu_a & bus.alu_b;
            4'b0001: alu_res = bus.alu_a | bus.alu_b;
            4'b0010: alu_res = bus.alu_a + bus.alu_b;
            4'b0110: alu_res = bus.alu_a - bus.alu_b;
            4'b0111: alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            4'b1000: alu_res = bus.alu_b << bus.alu_shamt;
            4'b1001: alu_res = bus.alu_b >> bus.alu_shamt;
            default: alu_res = '0;
        endcase
        bus.alu_result = alu_res;
        bus.alu_zero   = (alu_res == '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input bit k, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] ctrl,
                         input logic [31:0] exp_res, input logic exp_zero, input string tag);
        if (k == 1'b0) begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_shamt0 = sh; bus.req_ctrl0 = ctrl;
            bus.req_valid = 2'b01;
        end else begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_shamt1 = sh; bus.req_ctrl1 = ctrl;
            bus.req_valid = 2'b10;
        end
        @(negedge clk);
        check({tag, " req_ready"}, 64'(bus.req_ready), k ? 64'h2 : 64'h1);
        check({tag, " rsp_valid_N"}, 64'(bus.rsp_valid), 64'h0);
        go();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check({tag, " alu_a"}, 64'(bus.alu_a), 64'(a));
        check({tag, " alu_b"}, 64'(bus.alu_b), 64'(b));
        check({tag, " alu_shamt"}, 64'(bus.alu_shamt), 64'(sh));
        check({tag, " alu_control"}, 64'(bus.alu_control), 64'(ctrl));
        check({tag, " req_ready_exec"}, 64'(bus.req_ready), 64'h0);
        check({tag, " rsp_valid_exec"}, 64'(bus.rsp_valid), 64'h0);
        go();
        @(negedge clk);
        check({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'h1);
        check({tag, " rsp_result"}, 64'(bus.rsp_result), 64'(exp_res));
        check({tag, " rsp_zero"}, 64'(bus.rsp_zero), 64'(exp_zero));
        check({tag, " rsp_id"}, 64'(bus.rsp_id), 64'(k));
        check({tag, " alu_control_resp"}, 64'(bus.alu_control), 64'h0);
        go();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_k;
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_shamt0 = '0; bus.req_ctrl0 = '0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_shamt1 = '0; bus.req_ctrl1 = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with a pending request that must not see ready
        go();
        bus.req_valid = 2'b01;
        go();
        @(negedge clk);
        check("rst req_ready", 64'(bus.req_ready), 64'h0);
        check("rst rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst rsp_id", 64'(bus.rsp_id), 64'h0);
        check("rst rsp_result", 64'(bus.rsp_result), 64'h0);
        check("rst rsp_zero", 64'(bus.rsp_zero), 64'h0);
        check("rst alu_a", 64'(bus.alu_a), 64'h0);
        check("rst alu_control", 64'(bus.alu_control), 64'h0);
        go();
        rst_n = 1'b1;
        bus.req_valid = 2'b00;

        do_op(1'b0, 32'd5, 32'd7, 5'd0, 4'b0010, 32'd12, 1'b0, "add");
        do_op(1'b1, 32'd9, 32'd9, 5'd0, 4'b0110, 32'd0, 1'b1, "sub_zero");
        do_op(1'b0, 32'd0, 32'd1, 5'd31, 4'b1000, 32'h8000_0000, 1'b0, "sll");
        do_op(1'b0, 32'd0, 32'd1, 5'd31, 4'b1001, 32'd0, 1'b1, "srl");
        do_op(1'b1, 32'd3, 32'd4, 5'd0, 4'b1111, 32'd0, 1'b1, "unknown");

        // Contention: req0 ADD 1+1=2, req1 SUB 10-3=7, both held valid
        bus.req_a0 = 32'd1;  bus.req_b0 = 32'd1; bus.req_shamt0 = 5'd0; bus.req_ctrl0 = 4'b0010;
        bus.req_a1 = 32'd10; bus.req_b1 = 32'd3; bus.req_shamt1 = 5'd0; bus.req_ctrl1 = 4'b0110;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_k = 1'b0;
`else
            exp_k = i[0];
`endif
            @(negedge clk);
            check($sformatf("cont%0d req_ready", i), 64'(bus.req_ready), exp_k ? 64'h2 : 64'h1);
            go();
            @(negedge clk);
            check($sformatf("cont%0d req_ready_exec", i), 64'(bus.req_ready), 64'h0);
            go();
            @(negedge clk);
            check($sformatf("cont%0d rsp_id", i), 64'(bus.rsp_id), 64'(exp_k));
            check($sformatf("cont%0d rsp_result", i), 64'(bus.rsp_result), exp_k ? 64'd7 : 64'd2);
            go();
        end
        bus.req_valid = 2'b00;

        // Backpressure: req0 ADD 20+22=42 held in RESP, req1 SUB 100-1=99 waits
        bus.rsp_ready = 1'b0;
        bus.req_a0 = 32'd20; bus.req_b0 = 32'd22; bus.req_ctrl0 = 4'b0010;
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("bp req_ready0", 64'(bus.req_ready), 64'h1);
        go();
        bus.req_a1 = 32'd100; bus.req_b1 = 32'd1; bus.req_ctrl1 = 4'b0110;
        bus.req_valid = 2'b10;
        @(negedge clk);
        check("bp req_ready_exec", 64'(bus.req_ready), 64'h0);
        go();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d rsp_valid", i), 64'(bus.rsp_valid), 64'h1);
            check($sformatf("bp%0d rsp_result", i), 64'(bus.rsp_result), 64'd42);
            check($sformatf("bp%0d rsp_id", i), 64'(bus.rsp_id), 64'h0);
            check($sformatf("bp%0d rsp_zero", i), 64'(bus.rsp_zero), 64'h0);
            check($sformatf("bp%0d req_ready", i), 64'(bus.req_ready), 64'h0);
            go();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp release rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("bp release req_ready", 64'(bus.req_ready), 64'h0);
        go();
        @(negedge clk);
        check("bp req1 accepted", 64'(bus.req_ready), 64'h2);
        check("bp idle rsp_valid", 64'(bus.rsp_valid), 64'h0);
        go();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("bp req1 alu_a", 64'(bus.alu_a), 64'd100);
        go();
        @(negedge clk);
        check("bp req1 rsp_result", 64'(bus.rsp_result), 64'd99);
        check("bp req1 rsp_id", 64'(bus.rsp_id), 64'h1);
        go();

        // Reset mid-op: req0 ADD 3+4 aborted in EXEC, then a tie goes to requester 0
        bus.req_a0 = 32'd3; bus.req_b0 = 32'd4; bus.req_ctrl0 = 4'b0010;
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("rmid req_ready", 64'(bus.req_ready), 64'h1);
        go();
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        check("rmid alu_a_in_reset", 64'(bus.alu_a), 64'h0);
        go();
        rst_n = 1'b1;
        bus.req_a0 = 32'd6; bus.req_b0 = 32'd1; bus.req_ctrl0 = 4'b0110;
        bus.req_a1 = 32'd8; bus.req_b1 = 32'd8; bus.req_ctrl1 = 4'b0010;
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("rmid rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rmid rsp_result", 64'(bus.rsp_result), 64'h0);
        check("rmid rsp_id", 64'(bus.rsp_id), 64'h0);
        check("rmid tie grant", 64'(bus.req_ready), 64'h1);
        go();
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("rmid exec rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rmid exec alu_a", 64'(bus.alu_a), 64'd6);
        go();
        @(negedge clk);
        check("rmid rsp_valid_after", 64'(bus.rsp_valid), 64'h1);
        check("rmid rsp_result_after", 64'(bus.rsp_result), 64'd5);
        check("rmid rsp_id_after", 64'(bus.rsp_id), 64'h0);
        go();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
